// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone target among several initiators.
// Latency: grant registered one cycle after CYC; data/control muxed combinationally while owned.
// Backpressure: holder sees target STALL or outstanding-full; every non-holder sees STALL=1.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_cyc/i_stb/i_we           per-initiator Wishbone control (one bit each)
//   i_addr/i_sel/i_dat         per-initiator fields, packed, initiator k at [k*W +: W]
//   i_ack/i_err/i_rty          terminations routed only to the grant holder
//   i_stall                    per-initiator stall (1 for non-holders)
//   i_dat_r                    target read data, broadcast (qualify with i_ack)
//   t_*                        target-side Wishbone bus
//   grant                      registered one-hot grant, 0 when idle
module wishbone_arbiter #(
    parameter int Initiators     = 2,
    parameter int AddressWidth   = 16,
    parameter int DataWidth      = 8,
    parameter int Granularity    = 8,
    parameter int MaxOutstanding = 4
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [Initiators-1:0]                             i_cyc,
    input  logic [Initiators-1:0]                             i_stb,
    input  logic [Initiators-1:0]                             i_we,
    input  logic [Initiators*AddressWidth-1:0]                i_addr,
    input  logic [Initiators*(DataWidth/Granularity)-1:0]     i_sel,
    input  logic [Initiators*DataWidth-1:0]                   i_dat,
    output logic [Initiators-1:0]                             i_ack,
    output logic [Initiators-1:0]                             i_err,
    output logic [Initiators-1:0]                             i_rty,
    output logic [Initiators-1:0]                             i_stall,
    output logic [DataWidth-1:0]                              i_dat_r,
    output logic                                              t_cyc,
    output logic                                              t_stb,
    output logic                                              t_we,
    output logic [AddressWidth-1:0]                           t_addr,
    output logic [(DataWidth/Granularity)-1:0]                t_sel,
    output logic [DataWidth-1:0]                              t_dat,
    input  logic                                              t_ack,
    input  logic                                              t_err,
    input  logic                                              t_rty,
    input  logic                                              t_stall,
    input  logic [DataWidth-1:0]                              t_dat_r,
    output logic [Initiators-1:0]                             grant
);

    localparam int SW = DataWidth / Granularity;
    localparam int IW = $clog2(Initiators);
    localparam int CW = $clog2(MaxOutstanding + 1);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [Initiators-1:0]  grant_nxt;
    logic [IW-1:0]          gidx, gidx_nxt;     // index of the grant holder
    logic [IW-1:0]          last, last_nxt;     // last winner, rotation origin
    logic [CW-1:0]          count, count_nxt;   // accepted-but-unterminated requests
    logic [IW-1:0]          winner;
    logic                   found;
    logic                   full;
    logic                   accept;
    logic                   term;
    int                     idx;

    assign full   = (count == CW'(MaxOutstanding));
    assign accept = t_stb & ~t_stall;
    assign term   = t_ack | t_err | t_rty;

    // Search starts just after the last winner so simultaneous requesters rotate.
    always_comb begin
        winner = last;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= Initiators; k++) begin
            idx = (int'(last) + k) % Initiators;
            if (!found && i_cyc[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            last  <= IW'(Initiators - 1);
            count <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            gidx  <= gidx_nxt;
            last  <= last_nxt;
            count <= count_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        gidx_nxt  = gidx;
        last_nxt  = last;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = OWNED;
                    gidx_nxt  = winner;
                    last_nxt  = winner;
                    grant_nxt = Initiators'(1) << winner;
                    count_nxt = '0;
                end
            end
            OWNED: begin
                if (!i_cyc[gidx]) begin
                    // Holder ended its cycle: drop the grant and forget outstanding work.
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    count_nxt = '0;
                end else if (accept && !term) begin
                    count_nxt = count + CW'(1);
                end else if (!accept && term && (count != '0)) begin
                    // A termination with nothing outstanding is ignored rather than wrapping.
                    count_nxt = count - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                count_nxt = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        t_cyc   = 1'b0;
        t_stb   = 1'b0;
        i_ack   = '0;
        i_err   = '0;
        i_rty   = '0;
        i_stall = '1;
        if (state == OWNED) begin
            t_cyc         = i_cyc[gidx];
            // STB is never presented without CYC, and is withheld while full.
            t_stb         = i_cyc[gidx] & i_stb[gidx] & ~full;
            i_stall[gidx] = t_stall | full;
            i_ack[gidx]   = t_ack;
            i_err[gidx]   = t_err;
            i_rty[gidx]   = t_rty;
        end
    end

    // Field muxing follows the holder index; only meaningful while t_cyc is high.
    assign t_we    = i_we[gidx];
    assign t_addr  = i_addr[int'(gidx)*AddressWidth +: AddressWidth];
    assign t_sel   = i_sel[int'(gidx)*SW +: SW];
    assign t_dat   = i_dat[int'(gidx)*DataWidth +: DataWidth];
    assign i_dat_r = t_dat_r;

endmodule

// File: tb/tb_wishbone_arbiter.sv
module tb_wishbone_arbiter;

    localparam int N   = 2;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int SW  = 1;
    localparam int MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      i_cyc, i_stb, i_we;
    logic [N*AW-1:0]   i_addr;
    logic [N*SW-1:0]   i_sel;
    logic [N*DW-1:0]   i_dat;
    logic [N-1:0]      i_ack, i_err, i_rty, i_stall;
    logic [DW-1:0]     i_dat_r;
    logic              t_cyc, t_stb, t_we;
    logic [AW-1:0]     t_addr;
    logic [SW-1:0]     t_sel;
    logic [DW-1:0]     t_dat;
    logic              t_ack, t_err, t_rty, t_stall;
    logic [DW-1:0]     t_dat_r;
    logic [N-1:0]      grant;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wishbone_arbiter #(
        .Initiators(N), .AddressWidth(AW), .DataWidth(DW),
        .Granularity(8), .MaxOutstanding(MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_addr(i_addr),
        .i_sel(i_sel), .i_dat(i_dat),
        .i_ack(i_ack), .i_err(i_err), .i_rty(i_rty), .i_stall(i_stall),
        .i_dat_r(i_dat_r),
        .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_addr(t_addr),
        .t_sel(t_sel), .t_dat(t_dat),
        .t_ack(t_ack), .t_err(t_err), .t_rty(t_rty), .t_stall(t_stall),
        .t_dat_r(t_dat_r), .grant(grant)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, who won last, how many requests are open.
    int m_owner, m_last, m_cnt;
    int w_tmp;
    bit acc_tmp, trm_tmp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_last  <= N - 1;
            m_cnt   <= 0;
        end else if (m_owner < 0) begin
            w_tmp = -1;
            for (int k = 1; k <= N; k++)
                if (w_tmp < 0 && i_cyc[(m_last + k) % N]) w_tmp = (m_last + k) % N;
            if (w_tmp >= 0) begin
                m_owner <= w_tmp;
                m_last  <= w_tmp;
                m_cnt   <= 0;
            end
        end else if (!i_cyc[m_owner]) begin
            m_owner <= -1;
            m_cnt   <= 0;
        end else begin
            acc_tmp = i_stb[m_owner] && (m_cnt < MAX) && !t_stall;
            trm_tmp = t_ack || t_err || t_rty;
            if (acc_tmp && !trm_tmp)                    m_cnt <= m_cnt + 1;
            else if (!acc_tmp && trm_tmp && m_cnt > 0)  m_cnt <= m_cnt - 1;
        end
    end

    // Compare process: every cycle out of reset, on the falling edge.
    logic [N-1:0] e_grant, e_stall, e_ack, e_err, e_rty;
    logic         e_cyc, e_stb;
    always @(negedge clk) begin
        if (rst_n) begin
            e_grant = '0; e_stall = '1; e_ack = '0; e_err = '0; e_rty = '0;
            e_cyc = 1'b0; e_stb = 1'b0;
            if (m_owner >= 0) begin
                e_grant[m_owner] = 1'b1;
                e_cyc            = i_cyc[m_owner];
                e_stb            = i_cyc[m_owner] && i_stb[m_owner] && (m_cnt < MAX);
                e_stall[m_owner] = t_stall || (m_cnt == MAX);
                e_ack[m_owner]   = t_ack;
                e_err[m_owner]   = t_err;
                e_rty[m_owner]   = t_rty;
            end
            chk("grant", 64'(grant), 64'(e_grant));
            chk("t_cyc", 64'(t_cyc), 64'(e_cyc));
            chk("t_stb", 64'(t_stb), 64'(e_stb));
            chk("i_stall", 64'(i_stall), 64'(e_stall));
            chk("i_ack", 64'(i_ack), 64'(e_ack));
            chk("i_err", 64'(i_err), 64'(e_err));
            chk("i_rty", 64'(i_rty), 64'(e_rty));
            chk("i_dat_r", 64'(i_dat_r), 64'(t_dat_r));
            if (e_cyc)
                chk("t_fields", 64'({t_we, t_addr, t_sel, t_dat}),
                    64'({i_we[m_owner], i_addr[m_owner*AW +: AW],
                         i_sel[m_owner*SW +: SW], i_dat[m_owner*DW +: DW]}));
        end
    end

    task automatic clear_inputs();
        i_cyc = '0; i_stb = '0; i_we = '0; i_addr = '0; i_sel = '0; i_dat = '0;
        t_ack = 1'b0; t_err = 1'b0; t_rty = 1'b0; t_stall = 1'b0; t_dat_r = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; pulses reset well clear of any edge.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        clear_inputs();
        #2 rst_n = 1'b1;
    endtask

    int n_acc;
    int r;

    initial begin
        clear_inputs();
        #13 rst_n = 1'b1;

        // 1: single write from initiator 0
        tick();
        chk("reset_stall", 64'(i_stall), 64'h3);
        chk("reset_grant", 64'(grant), 64'h0);
        i_cyc = 2'b01; i_stb = 2'b01; i_we = 2'b01; i_sel = 1'b1;
        i_addr[15:0] = 16'h0010; i_dat[7:0] = 8'h5A;
        #3 chk("t1_tcyc_before_grant", 64'(t_cyc), 64'h0);
        tick();
        t_ack = 1'b1;
        #3;
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_t_addr", 64'(t_addr), 64'h10);
        chk("t1_t_dat", 64'(t_dat), 64'h5A);
        chk("t1_i_ack", 64'(i_ack), 64'h1);
        tick();
        do_reset();

        // 2: both request continuously, each releases after one transfer
        tick();
        i_cyc = 2'b11;
        tick(); #3 chk("t2_grant_a", 64'(grant), 64'h1);
        tick(); i_stb = 2'b01; t_ack = 1'b1;
        tick(); i_stb = 2'b00; t_ack = 1'b0; i_cyc = 2'b10;
        tick(); #3 chk("t2_grant_b", 64'(grant), 64'h0);
        i_cyc = 2'b11;
        tick(); #3 chk("t2_grant_c", 64'(grant), 64'h2);
        i_stb = 2'b10; t_ack = 1'b1;
        tick(); i_stb = 2'b00; t_ack = 1'b0; i_cyc = 2'b01;
        tick(); #3 chk("t2_grant_d", 64'(grant), 64'h0);
        i_cyc = 2'b11;
        tick(); #3 chk("t2_grant_e", 64'(grant), 64'h1);
        tick();
        do_reset();

        // 3: target never terminates; four accepts fill the window
        tick();
        i_cyc = 2'b01; i_stb = 2'b01;
        tick();
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            #3 if (t_stb && !t_stall) n_acc++;
            tick();
        end
        chk("t3_accepts", 64'(n_acc), 64'd4);
        #3;
        chk("t3_full_stall", 64'(i_stall[0]), 64'h1);
        chk("t3_full_stb", 64'(t_stb), 64'h0);
        tick(); t_ack = 1'b1;
        #3 chk("t3_ack_cycle_stb", 64'(t_stb), 64'h0);
        tick(); t_ack = 1'b0;
        #3 chk("t3_reaccept", 64'(t_stb), 64'h1);
        tick();
        #3 chk("t3_full_again", 64'(t_stb), 64'h0);
        tick();
        do_reset();

        // 4: accept and ACK together at count 2 leaves count at 2
        tick();
        i_cyc = 2'b01; i_stb = 2'b01;
        tick(); tick(); tick();
        t_ack = 1'b1;
        #3;
        chk("t4_model_cnt", 64'(m_cnt), 64'd2);
        chk("t4_no_stall", 64'(i_stall[0]), 64'h0);
        tick(); t_ack = 1'b0;
        chk("t4_cnt_hold", 64'(m_cnt), 64'd2);
        #3 chk("t4_stb_a", 64'(t_stb), 64'h1);
        tick(); #3 chk("t4_stb_b", 64'(t_stb), 64'h1);
        tick(); #3 chk("t4_stb_full", 64'(t_stb), 64'h0);
        tick();
        do_reset();

        // 5: I1 waits while I0's read completes
        tick();
        i_cyc = 2'b01; i_stb = 2'b01;
        tick(); tick();
        i_stb = 2'b00; i_cyc = 2'b11;
        #3 chk("t5_i1_stalled", 64'(i_stall[1]), 64'h1);
        tick();
        t_ack = 1'b1; t_dat_r = 8'hC3;
        #3;
        chk("t5_ack_routed", 64'(i_ack), 64'h1);
        chk("t5_dat_r", 64'(i_dat_r), 64'hC3);
        chk("t5_grant_kept", 64'(grant), 64'h1);
        tick();
        do_reset();

        // 6: asynchronous reset mid-burst
        tick();
        i_cyc = 2'b01; i_stb = 2'b01;
        tick(); tick(); tick(); tick();
        i_stb = 2'b00;
        #2 chk("t6_model_cnt", 64'(m_cnt), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_t_cyc", 64'(t_cyc), 64'h0);
        chk("t6_grant", 64'(grant), 64'h0);
        chk("t6_stall", 64'(i_stall), 64'h3);
        clear_inputs();
        #2 rst_n = 1'b1;
        i_cyc = 2'b11;
        tick(); #3 chk("t6_first_winner", 64'(grant), 64'h1);
        tick();
        do_reset();

        // Randomised traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (i_cyc[k]) begin
                    if ($urandom_range(7) == 0) i_cyc[k] = 1'b0;
                end else if ($urandom_range(5) == 0) begin
                    i_cyc[k] = 1'b1;
                end
                i_stb[k] = i_cyc[k] & 1'($urandom_range(1));
            end
            i_we    = N'($urandom);
            i_addr  = (N*AW)'($urandom);
            i_sel   = (N*SW)'($urandom);
            i_dat   = (N*DW)'($urandom);
            r       = int'($urandom_range(19));
            t_ack   = (r < 5);
            t_err   = (r == 5);
            t_rty   = (r == 6);
            t_stall = ($urandom_range(3) == 0);
            t_dat_r = DW'($urandom);
        end
        tick();
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
